rat_reduce: RTL and testbench

- Normalisation stage directly downstream of the rational multiply/divide unit (mul_div).
- Accepts an unreduced product fraction s_num/s_den and divides both terms by their GCD, so results stay in lowest terms before the next rational operation.
- GCD uses an iterative binary (Stein) algorithm. Division by the GCD uses two parallel sequential restoring dividers.
- Valid/ready handshake on both sides.

---
 rtl/rat_pkg.sv | 31 +++
 rtl/rat_seq_div.sv | 93 +++++++++
 rtl/rat_reduce.sv | 180 ++++++++++++++++++
 tb/tb_rat_reduce.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared definitions for the rational reduction stage.
//   - state_t     : controller states of rat_reduce
//   - cnt_width() : width of the shift/iteration counters for a given WIDTH
//   - max_latency(): worst-case input-transfer to out_valid latency
//   - WIDTH_DEF, CNT_W, MAX_LAT : the same values for the default 32-bit build
package rat_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        STRIP,
        GCD,
        DIV,
        DONE
    } state_t;

    // Wide enough to hold the value WIDTH itself (divider step count, and
    // the common power-of-two exponent k which can reach WIDTH-1).
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    function automatic int max_latency(input int w);
        return 4 * w + 4;
    endfunction

    localparam int CNT_W   = cnt_width(WIDTH_DEF);
    localparam int MAX_LAT = max_latency(WIDTH_DEF);

endpackage

// File: rtl/rat_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start         load dividend/divisor and begin (ignored values otherwise)
//   dividend      WIDTH-bit unsigned dividend
//   divisor       WIDTH-bit unsigned divisor (caller guarantees non-zero)
//   quotient      WIDTH-bit quotient, valid from the cycle done is high
//   done          one-cycle pulse after exactly WIDTH iteration cycles
// The remainder is kept internally only; callers here always divide exactly.
module rat_seq_div
    import rat_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Partial remainder shifted left with the next dividend bit; one extra
    // bit because it can exceed WIDTH bits before the trial subtraction.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = (shifted >= {1'b0, dvs_q});

    // NOTE: every combinational output gets a default first so no path
    // through the case/if tree leaves it unassigned (which would infer a latch).
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CW'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], fits};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values; reset is synchronous (sampled
    // only at the clock edge), so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/rat_reduce.sv
// Reduces an unsigned fraction in_num/in_den to lowest terms.
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   in_valid/in_ready      input handshake; accepts only when idle
//   in_num, in_den         unreduced fraction
//   out_valid/out_ready    output handshake; result held until accepted
//   out_num, out_den       reduced fraction
//   out_err                input denominator was zero (out_num=in_num, out_den=0)
// Flow: strip common factors of two (count k), binary GCD on the odd
// remainder, then divide both terms by g = b<<k in two parallel dividers.
module rat_reduce
    import rat_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic             out_err
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] out_num_q, out_num_d;
    logic [WIDTH-1:0] out_den_q, out_den_d;
    logic             out_err_q, out_err_d;

    logic [WIDTH-1:0] g;
    logic             div_start;
    logic [WIDTH-1:0] num_quo, den_quo;
    logic             num_done, den_done;

    // The GCD terminates when a reaches zero; the dividers are launched on
    // that same edge with the restored power-of-two factor.
    assign g         = b_q << k_q;
    assign div_start = (state_q == GCD) && (a_q == '0);

    rat_seq_div #(.WIDTH(WIDTH)) u_div_num (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (n_q),
        .divisor  (g),
        .quotient (num_quo),
        .done     (num_done)
    );

    rat_seq_div #(.WIDTH(WIDTH)) u_div_den (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (d_q),
        .divisor  (g),
        .quotient (den_quo),
        .done     (den_done)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        n_d       = n_q;
        d_d       = d_q;
        k_d       = k_q;
        out_num_d = out_num_q;
        out_den_d = out_den_q;
        out_err_d = out_err_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = in_num;
                    b_d = in_den;
                    n_d = in_num;
                    d_d = in_den;
                    k_d = '0;
                    if (in_den == '0) begin
                        out_num_d = in_num;
                        out_den_d = '0;
                        out_err_d = 1'b1;
                        state_d   = DONE;
                    end else if (in_num == '0) begin
                        out_num_d = '0;
                        out_den_d = WIDTH'(1);
                        out_err_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        state_d = STRIP;
                    end
                end
            end
            STRIP: begin
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + CW'(1);
                end else begin
                    state_d = GCD;
                end
            end
            GCD: begin
                if (a_q == '0) begin
                    state_d = DIV;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q >= b_q) begin
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            DIV: begin
                // Both dividers start together and take the same number of
                // cycles, so one done is enough.
                if (num_done) begin
                    out_num_d = num_quo;
                    out_den_d = den_quo;
                    out_err_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            n_q       <= '0;
            d_q       <= '0;
            k_q       <= '0;
            out_num_q <= '0;
            out_den_q <= WIDTH'(1);
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            n_q       <= n_d;
            d_q       <= d_d;
            k_q       <= k_d;
            out_num_q <= out_num_d;
            out_den_q <= out_den_d;
            out_err_q <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_num   = out_num_q;
    assign out_den   = out_den_q;
    assign out_err   = out_err_q;

    // den_done mirrors num_done by construction; kept connected for symmetry.
    logic unused_den_done;
    assign unused_den_done = den_done;

endmodule

// File: tb/tb_rat_reduce.sv
// Directed self-checking bench for rat_reduce: reset values, zero and error
// cases, power-of-two, coprime, equal terms, backpressure, mid-job reset and
// a chain of products of small operands checked against a Euclid model.
module tb_rat_reduce;
    import rat_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_num;
    logic [W-1:0] in_den;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_num;
    logic [W-1:0] out_den;
    logic         out_err;

    int checks   = 0;
    int failures = 0;

    rat_reduce #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_den   (out_den),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] gcd64(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [W-1:0] num, input logic [W-1:0] den);
        int w;
        w = 0;
        while (!in_ready && w < MAX_LAT) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("send_ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_num   = num;
        in_den   = den;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts negedges after the transfer until out_valid, bounded.
    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < MAX_LAT);
        check({tag, "_valid_in_time"}, out_valid, 1);
    endtask

    task automatic run_job(input string tag, input logic [W-1:0] num, input logic [W-1:0] den,
                           input logic [W-1:0] enum_, input logic [W-1:0] eden, input logic eerr);
        int lat;
        out_ready = 1'b1;
        send(num, den);
        wait_out(tag, lat);
        check({tag, "_num"}, out_num, enum_);
        check({tag, "_den"}, out_den, eden);
        check({tag, "_err"}, out_err, eerr);
        @(negedge clk);
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [W-1:0] held_num, held_den;
        logic [63:0] num64, den64, g64;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_num", out_num, 0);
        check("rst_out_den", out_den, 1);
        check("rst_out_err", out_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // 12/18 -> 2/3 with out_ready held high.
        run_job("r12_18", 12, 18, 2, 3, 0);

        // Zero numerator: one cycle latency.
        out_ready = 1'b1;
        send(0, 7);
        wait_out("z0_7", lat);
        check("z0_7_latency", lat, 1);
        check("z0_7_num", out_num, 0);
        check("z0_7_den", out_den, 1);
        check("z0_7_err", out_err, 0);
        @(negedge clk);

        run_job("e5_0", 5, 0, 5, 0, 1);
        run_job("e0_0", 0, 0, 0, 0, 1);
        run_job("pow2", 32'h8000_0000, 32'h4000_0000, 2, 1, 0);
        run_job("coprime", 7, 13, 7, 13, 0);
        run_job("equal", 999, 999, 1, 1, 0);

        // Backpressure: result held 20 cycles while input pulses are refused.
        out_ready = 1'b0;
        send(998001, 2997);
        wait_out("bp", lat);
        check("bp_num", out_num, 333);
        check("bp_den", out_den, 1);
        check("bp_err", out_err, 0);
        held_num = out_num;
        held_den = out_den;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_num   = W'(i + 2);
            in_den   = W'(i + 3);
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_num", out_num, 333);
            check("bp_hold_den", out_den, 1);
            check("bp_in_ready_low", in_ready, 0);
        end
        check("bp_stable_num", held_num, out_num);
        check("bp_stable_den", held_den, out_den);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        repeat (5) @(negedge clk);
        check("bp_no_phantom_valid", out_valid, 0);
        check("bp_no_phantom_ready", in_ready, 1);

        // Reset in the middle of a job.
        send(12, 18);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mr_in_ready", in_ready, 1);
        check("mr_out_valid", out_valid, 0);
        check("mr_out_num", out_num, 0);
        check("mr_out_den", out_den, 1);
        check("mr_out_err", out_err, 0);
        seen = 1'b0;
        for (int i = 0; i < MAX_LAT + 10; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("mr_no_result", seen, 0);
        run_job("after_rst", 4, 6, 2, 3, 0);

        // Chained products of operands below 1000.
        out_ready = 1'b1;
        for (int j = 0; j < 200; j++) begin
            num64 = 64'($urandom_range(0, 999)) * 64'($urandom_range(0, 999));
            den64 = 64'($urandom_range(1, 999)) * 64'($urandom_range(1, 999));
            g64   = gcd64(num64, den64);
            send(num64[W-1:0], den64[W-1:0]);
            wait_out("rnd", lat);
            check("rnd_num", out_num, num64 / g64);
            check("rnd_den", out_den, den64 / g64);
            check("rnd_err", out_err, 0);
            check("rnd_cross", 64'(out_num) * den64, 64'(out_den) * num64);
            check("rnd_coprime", gcd64(64'(out_num), 64'(out_den)), 1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
